// File: rtl/seg_scan_display_pkg.sv
// Shared glyph codes and segment patterns for the multiplexed seven-segment driver.
// Segment bit order is {a,b,c,d,e,f,g,dp}, active-high.
package seg_pkg;

  localparam logic [4:0] GLY_DASH  = 5'h10;
  localparam logic [4:0] GLY_P     = 5'h11;
  localparam logic [4:0] GLY_L     = 5'h12;
  localparam logic [4:0] GLY_H     = 5'h13;
  localparam logic [4:0] GLY_U     = 5'h14;
  localparam logic [4:0] GLY_BLANK = 5'h1F;

  localparam logic [7:0] SEG_OFF  = 8'b0000_0000;
  localparam logic [7:0] SEG_0    = 8'b1111_1100;
  localparam logic [7:0] SEG_1    = 8'b0110_0000;
  localparam logic [7:0] SEG_2    = 8'b1101_1010;
  localparam logic [7:0] SEG_3    = 8'b1111_0010;
  localparam logic [7:0] SEG_4    = 8'b0110_0110;
  localparam logic [7:0] SEG_5    = 8'b1011_0110;
  localparam logic [7:0] SEG_6    = 8'b1011_1110;
  localparam logic [7:0] SEG_7    = 8'b1110_0000;
  localparam logic [7:0] SEG_8    = 8'b1111_1110;
  localparam logic [7:0] SEG_9    = 8'b1111_0110;
  localparam logic [7:0] SEG_A    = 8'b1110_1110;
  localparam logic [7:0] SEG_B    = 8'b0011_1110;
  localparam logic [7:0] SEG_C    = 8'b1001_1100;
  localparam logic [7:0] SEG_D    = 8'b0111_1010;
  localparam logic [7:0] SEG_E    = 8'b1001_1110;
  localparam logic [7:0] SEG_F    = 8'b1000_1110;
  localparam logic [7:0] SEG_DASH = 8'b0000_0010;
  localparam logic [7:0] SEG_P    = 8'b1100_1110;
  localparam logic [7:0] SEG_L    = 8'b0001_1100;
  localparam logic [7:0] SEG_H    = 8'b0110_1110;
  localparam logic [7:0] SEG_U    = 8'b0111_1100;

endpackage

// File: rtl/seg_scan_display_if.sv
// Picture-load and pin-side signals of the scan driver; master is the mode/status logic.
interface seg_scan_display_if #(
  parameter int DIGITS = 8
);
  logic                  enable;
  logic                  load;
  logic [5*DIGITS-1:0]   codes;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0]     blink_mask;
  logic [7:0]            seg;
  logic [DIGITS-1:0]     tubsel;
  logic                  busy;

  modport master (
    output enable, load, codes, dp_mask, blink_mask,
    input  seg, tubsel, busy
  );

  modport slave (
    input  enable, load, codes, dp_mask, blink_mask,
    output seg, tubsel, busy
  );
endinterface

// File: rtl/seg_glyph_decode.sv
// Combinational 5-bit glyph code to segments a..g; the decimal point is added by the caller.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [4:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    // NOTE: the default assignment before the case keeps every path driven, so no latch.
    seg_o = SEG_OFF[7:1];
    unique case (code_i)
      5'h00:    seg_o = SEG_0[7:1];
      5'h01:    seg_o = SEG_1[7:1];
      5'h02:    seg_o = SEG_2[7:1];
      5'h03:    seg_o = SEG_3[7:1];
      5'h04:    seg_o = SEG_4[7:1];
      5'h05:    seg_o = SEG_5[7:1];
      5'h06:    seg_o = SEG_6[7:1];
      5'h07:    seg_o = SEG_7[7:1];
      5'h08:    seg_o = SEG_8[7:1];
      5'h09:    seg_o = SEG_9[7:1];
      5'h0A:    seg_o = SEG_A[7:1];
      5'h0B:    seg_o = SEG_B[7:1];
      5'h0C:    seg_o = SEG_C[7:1];
      5'h0D:    seg_o = SEG_D[7:1];
      5'h0E:    seg_o = SEG_E[7:1];
      5'h0F:    seg_o = SEG_F[7:1];
      GLY_DASH: seg_o = SEG_DASH[7:1];
      GLY_P:    seg_o = SEG_P[7:1];
      GLY_L:    seg_o = SEG_L[7:1];
      GLY_H:    seg_o = SEG_H[7:1];
      GLY_U:    seg_o = SEG_U[7:1];
      default:  seg_o = SEG_OFF[7:1];
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed seven-segment scanner with double-buffered picture, blanking and blink.
// A new picture is copied into the shadow only at a frame boundary so a frame never tears.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 12500,
  parameter int BLANK_CYC    = 16,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_scan_display_if.slave  bus
);

  localparam int DIV_W = (SCAN_DIV > 1)     ? $clog2(SCAN_DIV)     : 1;
  localparam int IDX_W = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic [5*DIGITS-1:0] pend_codes_q, pend_codes_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d, pend_blink_q, pend_blink_d;
  logic [5*DIGITS-1:0] shad_codes_q, shad_codes_d;
  logic [DIGITS-1:0]   shad_dp_q, shad_dp_d, shad_blink_q, shad_blink_d;
  logic                busy_q, busy_d;
  logic [7:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   tubsel_q, tubsel_d;
  logic                div_wrap, frame_wrap, lit;
  logic [6:0]          glyph_seg;

  assign div_wrap   = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
  assign frame_wrap = bus.enable && div_wrap && (idx_q == IDX_W'(DIGITS - 1));

  always_comb begin
    div_cnt_d     = '0;
    idx_d         = '0;
    blink_cnt_d   = '0;
    blink_phase_d = 1'b0;
    if (bus.enable) begin
      div_cnt_d     = div_wrap ? '0 : div_cnt_q + 1'b1;
      idx_d         = idx_q;
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (div_wrap) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      if (frame_wrap) begin
        if (blink_cnt_q == BLK_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d   = '0;
          blink_phase_d = ~blink_phase_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // A load that cannot wait (scan stopped, or coinciding with the wrap) bypasses pending.
  always_comb begin
    pend_codes_d = pend_codes_q;
    pend_dp_d    = pend_dp_q;
    pend_blink_d = pend_blink_q;
    shad_codes_d = shad_codes_q;
    shad_dp_d    = shad_dp_q;
    shad_blink_d = shad_blink_q;
    busy_d       = busy_q;
    if (bus.load && (!bus.enable || frame_wrap)) begin
      shad_codes_d = bus.codes;
      shad_dp_d    = bus.dp_mask;
      shad_blink_d = bus.blink_mask;
      busy_d       = 1'b0;
    end else begin
      if (frame_wrap && busy_q) begin
        shad_codes_d = pend_codes_q;
        shad_dp_d    = pend_dp_q;
        shad_blink_d = pend_blink_q;
        busy_d       = 1'b0;
      end
      if (bus.load) begin
        pend_codes_d = bus.codes;
        pend_dp_d    = bus.dp_mask;
        pend_blink_d = bus.blink_mask;
        busy_d       = 1'b1;
      end
    end
  end

  seg_glyph_decode u_decode (
    .code_i (shad_codes_q[int'(idx_q)*5 +: 5]),
    .seg_o  (glyph_seg)
  );

  always_comb begin
    lit      = (int'(div_cnt_q) >= BLANK_CYC) && !(blink_phase_q && shad_blink_q[idx_q]);
    seg_d    = SEG_OFF;
    tubsel_d = '0;
    if (bus.enable) begin
      tubsel_d = DIGITS'(1) << idx_q;
      if (lit) seg_d = {glyph_seg, shad_dp_q[idx_q]};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      div_cnt_q     <= '0;
      idx_q         <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      shad_codes_q  <= {DIGITS{GLY_BLANK}};
      shad_dp_q     <= '0;
      shad_blink_q  <= '0;
      busy_q        <= 1'b0;
      seg_q         <= SEG_OFF;
      tubsel_q      <= '0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      idx_q         <= idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shad_codes_q  <= shad_codes_d;
      shad_dp_q     <= shad_dp_d;
      shad_blink_q  <= shad_blink_d;
      busy_q        <= busy_d;
      seg_q         <= seg_d;
      tubsel_q      <= tubsel_d;
    end
  end

  // NOTE: pending data is left unreset; busy_q alone decides whether it is ever used.
  always_ff @(posedge clk) begin
    pend_codes_q <= pend_codes_d;
    pend_dp_q    <= pend_dp_d;
    pend_blink_q <= pend_blink_d;
  end

  assign bus.seg    = seg_q;
  assign bus.tubsel = tubsel_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display: glyph table, double buffering, blink, enable and reset.
module tb_seg_scan_display;

  localparam int DIGITS       = 4;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYC    = 2;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME        = DIGITS * SCAN_DIV;

  typedef struct {
    logic [4:0] code;
    logic       dp;
    logic [7:0] seg;
  } glyph_vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_scan_display_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_display #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int              n_tests = 0;
  int              n_fail  = 0;
  int              cyc     = 0;
  logic [7:0]      exp_seg [DIGITS];
  logic [DIGITS-1:0] exp_blink = '0;
  glyph_vec_t      gv [24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (scan cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // cyc counts enabled edges since the scan last restarted from zero.
  task automatic tick();
    @(posedge clk);
    if (rst_n && bus.enable) cyc++;
    else cyc = 0;
    #1;
  endtask

  function automatic logic [3:0] exp_tub();
    if (cyc == 0) return 4'b0000;
    return 4'b0001 << (((cyc - 1) / SCAN_DIV) % DIGITS);
  endfunction

  function automatic logic [7:0] exp_out();
    int slot, pos, frame;
    if (cyc == 0) return 8'h00;
    slot  = ((cyc - 1) / SCAN_DIV) % DIGITS;
    pos   = (cyc - 1) % SCAN_DIV;
    frame = (cyc - 1) / FRAME;
    if (pos < BLANK_CYC) return 8'h00;
    if (exp_blink[slot] && ((frame / BLINK_FRAMES) % 2 == 1)) return 8'h00;
    return exp_seg[slot];
  endfunction

  task automatic check_frames(input int n, input string name);
    for (int k = 0; k < n * FRAME; k++) begin
      tick();
      check({name, " tubsel"}, bus.tubsel, exp_tub());
      check({name, " seg"}, bus.seg, exp_out());
    end
  endtask

  task automatic load_pulse(input logic [19:0] codes, input logic [3:0] dp, input logic [3:0] blink);
    bus.codes      = codes;
    bus.dp_mask    = dp;
    bus.blink_mask = blink;
    bus.load       = 1'b1;
    tick();
    bus.load       = 1'b0;
  endtask

  task automatic wait_busy_clear(input string name);
    int k = 0;
    while (bus.busy && k < 100) begin
      tick();
      k++;
    end
    check({name, " busy cleared"}, bus.busy, 1'b0);
  endtask

  task automatic set_exp(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2,
                         input logic [7:0] s3, input logic [3:0] blink);
    exp_seg[0] = s0; exp_seg[1] = s1; exp_seg[2] = s2; exp_seg[3] = s3;
    exp_blink  = blink;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    gv[0]  = '{5'h00, 1'b0, 8'hFC}; gv[1]  = '{5'h01, 1'b1, 8'h61};
    gv[2]  = '{5'h02, 1'b0, 8'hDA}; gv[3]  = '{5'h03, 1'b0, 8'hF2};
    gv[4]  = '{5'h04, 1'b0, 8'h66}; gv[5]  = '{5'h05, 1'b1, 8'hB7};
    gv[6]  = '{5'h06, 1'b0, 8'hBE}; gv[7]  = '{5'h07, 1'b0, 8'hE0};
    gv[8]  = '{5'h08, 1'b0, 8'hFE}; gv[9]  = '{5'h09, 1'b0, 8'hF6};
    gv[10] = '{5'h0A, 1'b0, 8'hEE}; gv[11] = '{5'h0B, 1'b1, 8'h3F};
    gv[12] = '{5'h0C, 1'b0, 8'h9C}; gv[13] = '{5'h0D, 1'b0, 8'h7A};
    gv[14] = '{5'h0E, 1'b0, 8'h9E}; gv[15] = '{5'h0F, 1'b0, 8'h8E};
    gv[16] = '{5'h10, 1'b0, 8'h02}; gv[17] = '{5'h11, 1'b0, 8'hCE};
    gv[18] = '{5'h12, 1'b1, 8'h1D}; gv[19] = '{5'h13, 1'b0, 8'h6E};
    gv[20] = '{5'h14, 1'b0, 8'h7C}; gv[21] = '{5'h15, 1'b0, 8'h00};
    gv[22] = '{5'h1E, 1'b1, 8'h01}; gv[23] = '{5'h1F, 1'b0, 8'h00};

    bus.enable = 1'b0; bus.load = 1'b0;
    bus.codes = {DIGITS{5'h1F}}; bus.dp_mask = '0; bus.blink_mask = '0;
    set_exp(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);

    // Reset state
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset seg", bus.seg, 8'h00);
    check("reset tubsel", bus.tubsel, 4'b0000);
    check("reset busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    tick();
    check("disabled tubsel", bus.tubsel, 4'b0000);

    // Blank scan after reset
    bus.enable = 1'b1;
    check_frames(2, "blank scan");

    // Spec example load mid-frame; busy must hold until the frame wrap
    repeat (5) tick();
    load_pulse({5'h1F, 5'h1F, 5'h02, 5'h00}, 4'b0001, 4'b0000);
    check("busy after load", bus.busy, 1'b1);
    for (int k = 0; k < 2 * FRAME && (cyc % FRAME) != 0; k++) begin
      tick();
      check("busy until wrap", bus.busy, (cyc % FRAME) != 0);
    end
    set_exp(8'hFD, 8'hDA, 8'h00, 8'h00, 4'b0000);
    check_frames(1, "example picture");

    // Glyph table, four digits per load
    for (int g = 0; g < 6; g++) begin
      repeat (3) tick();
      load_pulse({gv[4*g+3].code, gv[4*g+2].code, gv[4*g+1].code, gv[4*g].code},
                 {gv[4*g+3].dp, gv[4*g+2].dp, gv[4*g+1].dp, gv[4*g].dp}, 4'b0000);
      wait_busy_clear("glyph group");
      set_exp(gv[4*g].seg, gv[4*g+1].seg, gv[4*g+2].seg, gv[4*g+3].seg, 4'b0000);
      check_frames(1, "glyph group");
    end

    // Two loads in one frame: last one wins
    repeat (4) tick();
    load_pulse({5'h1F, 5'h1F, 5'h1F, 5'h01}, 4'b0000, 4'b0000);
    repeat (5) tick();
    load_pulse({5'h1F, 5'h1F, 5'h1F, 5'h08}, 4'b0000, 4'b0000);
    wait_busy_clear("double load");
    set_exp(8'hFE, 8'h00, 8'h00, 8'h00, 4'b0000);
    check_frames(1, "double load");

    // Load on the exact wrap cycle
    for (int k = 0; k < 2 * FRAME && (cyc % FRAME) != FRAME - 1; k++) tick();
    load_pulse({5'h1F, 5'h1F, 5'h1F, 5'h12}, 4'b0000, 4'b0000);
    check("wrap load busy", bus.busy, 1'b0);
    set_exp(8'h1C, 8'h00, 8'h00, 8'h00, 4'b0000);
    check_frames(1, "wrap load");
    check("wrap load busy after", bus.busy, 1'b0);

    // Blink on digit0 only
    repeat (6) tick();
    load_pulse({5'h1F, 5'h1F, 5'h01, 5'h08}, 4'b0000, 4'b0001);
    wait_busy_clear("blink");
    set_exp(8'hFE, 8'h60, 8'h00, 8'h00, 4'b0001);
    check_frames(4, "blink");

    // Enable drop mid-frame, then restart with the retained shadow
    repeat (10) tick();
    bus.enable = 1'b0;
    tick();
    check("disable seg", bus.seg, 8'h00);
    check("disable tubsel", bus.tubsel, 4'b0000);
    repeat (3) tick();
    check("disabled hold tubsel", bus.tubsel, 4'b0000);
    bus.enable = 1'b1;
    check_frames(1, "re-enable");

    // Load while disabled goes straight to the shadow
    bus.enable = 1'b0;
    tick();
    load_pulse({5'h1F, 5'h1F, 5'h1F, 5'h13}, 4'b0010, 4'b0000);
    check("disabled load busy", bus.busy, 1'b0);
    bus.enable = 1'b1;
    set_exp(8'h6E, 8'h01, 8'h00, 8'h00, 4'b0000);
    check_frames(1, "disabled load");

    // Reset while a load is pending discards it
    repeat (5) tick();
    load_pulse({5'h00, 5'h00, 5'h00, 5'h00}, 4'b1111, 4'b0000);
    check("pending before reset", bus.busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("reset busy pending", bus.busy, 1'b0);
    check("reset seg pending", bus.seg, 8'h00);
    check("reset tubsel pending", bus.tubsel, 4'b0000);
    rst_n = 1'b1;
    set_exp(8'h00, 8'h00, 8'h00, 8'h00, 4'b0000);
    check_frames(2, "post reset");
    check("post reset busy", bus.busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
